// File: rtl/seq_cmp_pkg.sv
// Shared types and elaboration helpers for the sequential signed comparator.
//   state_e  : controller state (IDLE / RUN / DONE)
//   calc_n   : number of chunk cycles for a WIDTH/CHUNK pair
//   idx_w    : chunk index width, never below 1 bit
package seq_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_n(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   a, b : slice operands (unsigned)
//   gt   : a > b
//   lt   : a < b
module seq_cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_signed_cmp_gteq.sv
// Multi-cycle signed comparator: out_ge = (in_a >= in_b), two's complement.
// Operands are taken on an in_valid/in_ready handshake, walked LSB-first
// CHUNK bits per cycle, and the result is held on an out_valid/out_ready
// handshake.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (in_ready high only in IDLE)
//   in_a, in_b           : WIDTH-bit signed operands
//   out_valid/out_ready  : result handshake
//   out_ge               : A >= B
//   out_eq               : A == B (only when SEQ_CMP_EQ_OUT_EN is defined)
// Optional macro: SEQ_CMP_EQ_OUT_EN adds the out_eq port and its flag.
module seq_signed_cmp_gteq
  import seq_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SEQ_CMP_EQ_OUT_EN
  output logic             out_eq,
`endif
  output logic             out_ge
);

  localparam int N  = calc_n(WIDTH, CHUNK);
  localparam int IW = idx_w(N);

  generate
    if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_cfg
      $error("seq_signed_cmp_gteq: WIDTH must be >= 2 and divisible by CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ge_q, ge_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ge_q, out_ge_d;
`ifdef SEQ_CMP_EQ_OUT_EN
  logic             eq_q, eq_d;
  logic             out_eq_q, out_eq_d;
`endif

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_gt, c_lt;

  assign a_chunk = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_chunk = b_q[int'(idx_q)*CHUNK +: CHUNK];

  seq_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_chunk),
    .b  (b_chunk),
    .gt (c_gt),
    .lt (c_lt)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    ge_d        = ge_q;
    out_valid_d = out_valid_q;
    out_ge_d    = out_ge_q;
`ifdef SEQ_CMP_EQ_OUT_EN
    eq_d        = eq_q;
    out_eq_d    = out_eq_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps signed order onto unsigned order.
          a_d     = {~in_a[WIDTH-1], in_a[WIDTH-2:0]};
          b_d     = {~in_b[WIDTH-1], in_b[WIDTH-2:0]};
          ge_d    = 1'b1;
`ifdef SEQ_CMP_EQ_OUT_EN
          eq_d    = 1'b1;
`endif
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // LSB-first walk: any decisive higher chunk overrides lower ones.
        if (c_gt) begin
          ge_d = 1'b1;
`ifdef SEQ_CMP_EQ_OUT_EN
          eq_d = 1'b0;
`endif
        end else if (c_lt) begin
          ge_d = 1'b0;
`ifdef SEQ_CMP_EQ_OUT_EN
          eq_d = 1'b0;
`endif
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(N-1)) begin
          out_ge_d    = ge_d;
`ifdef SEQ_CMP_EQ_OUT_EN
          out_eq_d    = eq_d;
`endif
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      ge_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_ge_q    <= 1'b0;
`ifdef SEQ_CMP_EQ_OUT_EN
      eq_q        <= 1'b0;
      out_eq_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      ge_q        <= ge_d;
      out_valid_q <= out_valid_d;
      out_ge_q    <= out_ge_d;
`ifdef SEQ_CMP_EQ_OUT_EN
      eq_q        <= eq_d;
      out_eq_q    <= out_eq_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_ge    = out_ge_q;
`ifdef SEQ_CMP_EQ_OUT_EN
  assign out_eq    = out_eq_q;
`endif

endmodule

// File: tb/tb_seq_signed_cmp_gteq.sv
// Directed bench for seq_signed_cmp_gteq (WIDTH=32, CHUNK=4, N=8).
module tb_seq_signed_cmp_gteq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_ge;
`ifdef SEQ_CMP_EQ_OUT_EN
  logic        out_eq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_signed_cmp_gteq #(.WIDTH(32), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SEQ_CMP_EQ_OUT_EN
    .out_eq    (out_eq),
`endif
    .out_ge    (out_ge)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands, wait for the result, check latency and flags.
  // Leaves the DUT in DONE with out_valid high (result not yet consumed).
  task automatic start_and_wait(input string tag, input logic [31:0] a,
                                input logic [31:0] b, input logic exp_ge,
                                input logic exp_eq);
    int cyc;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 32'hDEAD_BEEF;
    in_b     = 32'h1234_5678;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd8);
    chk({tag, "_ge"}, 32'(out_ge), 32'(exp_ge));
`ifdef SEQ_CMP_EQ_OUT_EN
    chk({tag, "_eq"}, 32'(out_eq), 32'(exp_eq));
`else
    if (exp_eq === 1'bx) chk({tag, "_eq_unused"}, 32'(out_ge), 32'(exp_ge));
`endif
  endtask

  // Full compare with out_ready held high: result consumed on the next edge.
  task automatic do_cmp(input string tag, input logic [31:0] a,
                        input logic [31:0] b, input logic exp_ge,
                        input logic exp_eq);
    start_and_wait(tag, a, b, exp_ge, exp_eq);
    @(posedge clk); #1;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ge",    32'(out_ge),    32'd0);
`ifdef SEQ_CMP_EQ_OUT_EN
    chk("rst_out_eq",    32'(out_eq),    32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_cmp("eq5",     32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
    do_cmp("m1_vs_0", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);
    do_cmp("0_vs_m1", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    do_cmp("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    do_cmp("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
    do_cmp("hi_gt",   32'h0001_0000, 32'h0000_FFFF, 1'b1, 1'b0);
    do_cmp("hi_lt",   32'h0000_FFFF, 32'h0001_0000, 1'b0, 1'b0);
    do_cmp("neg_eq",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    do_cmp("neg_ord", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Backpressure: result and in_ready must hold while out_ready is low.
    out_ready = 1'b0;
    start_and_wait("bp", 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      in_a     = $urandom;
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_ge",    32'(out_ge),    32'd0);
      chk("bp_hold_ready", 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);

    // Reset three cycles into RUN: immediate return to idle, no result.
    in_valid = 1'b1;
    in_a     = 32'h0000_0009;
    in_b     = 32'h0000_0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    chk("midrst_ge",    32'(out_ge),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_no_valid", 32'(out_valid), 32'd0);
    do_cmp("postrst", 32'hFFFF_FF00, 32'h0000_0100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
